// File: rtl/id_regfile_scoreboard_pkg.sv
`default_nettype none
// ============================================================================
//  Package : mips_pkg
//  Purpose : Shared widths, sizes and helpers for the ID-stage register file
//            and its busy scoreboard.
//  Contents: DATA_W, ADDR_W, NUM_REGS, REG_ZERO, word_t, reg_addr_t and
//            writes_reg() (true when an enable targets a real register).
//  Revision: 1.0 - initial release
// ============================================================================
package mips_pkg;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 1 << ADDR_W;

  localparam logic [ADDR_W-1:0] REG_ZERO = 5'd0;

  typedef logic [DATA_W-1:0] word_t;
  typedef logic [ADDR_W-1:0] reg_addr_t;

  // Register 0 is hardwired, so an operation aimed at it never has an effect.
  function automatic logic writes_reg(input logic en, input reg_addr_t addr);
    return en && (addr != REG_ZERO);
  endfunction

endpackage
`default_nettype wire

// File: rtl/id_regfile_scoreboard_if.sv
`default_nettype none
// ============================================================================
//  Interface : id_regfile_scoreboard_if
//  Purpose   : Bundles the WB write port, the two ID read ports and the
//              producer-issue / stall handshake of the register file.
//  Signals   : wb_en, wb_addr, wb_data      - writeback request
//              rs_addr, rt_addr             - ID read addresses
//              rs_data, rt_data             - ID read data (combinational)
//              issue_en, issue_addr         - long-latency producer issue
//              stall                        - ID hold request
//  Modports  : master - pipeline side (drives requests, receives data/stall)
//              slave  - register file side
//  Revision  : 1.0 - initial release
// ============================================================================
interface id_regfile_scoreboard_if;
  import mips_pkg::*;

  logic      wb_en;
  reg_addr_t wb_addr;
  word_t     wb_data;
  reg_addr_t rs_addr;
  reg_addr_t rt_addr;
  word_t     rs_data;
  word_t     rt_data;
  logic      issue_en;
  reg_addr_t issue_addr;
  logic      stall;

  modport master (
    output wb_en, wb_addr, wb_data, rs_addr, rt_addr, issue_en, issue_addr,
    input  rs_data, rt_data, stall
  );

  modport slave (
    input  wb_en, wb_addr, wb_data, rs_addr, rt_addr, issue_en, issue_addr,
    output rs_data, rt_data, stall
  );

endinterface
`default_nettype wire

// File: rtl/id_regfile_scoreboard_busy_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module  : busy_scoreboard
//  Purpose : One busy bit per register, marking a pending long-latency
//            producer. Issue sets a bit, writeback clears it; when both hit
//            the same register in one cycle the set wins because the newly
//            issued producer supersedes the retiring one. Bit 0 stays clear.
//  Ports   : clk          in  clock, rising edge
//            rst          in  asynchronous active-low reset
//            set_en/addr  in  producer issue
//            clr_en/addr  in  writeback retire
//            look_a_addr  in  lookup port A address
//            look_b_addr  in  lookup port B address
//            look_a_busy  out lookup port A busy bit
//            look_b_busy  out lookup port B busy bit
//  Revision: 1.0 - initial release
// ============================================================================
module busy_scoreboard
  import mips_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      set_en,
  input  reg_addr_t set_addr,
  input  logic      clr_en,
  input  reg_addr_t clr_addr,
  input  reg_addr_t look_a_addr,
  input  reg_addr_t look_b_addr,
  output logic      look_a_busy,
  output logic      look_b_busy
);

  logic [NUM_REGS-1:0] r_busy;
  logic [NUM_REGS-1:0] w_set_vec;
  logic [NUM_REGS-1:0] w_clr_vec;

  // writes_reg() excludes register 0, so bit 0 can never be set.
  assign w_set_vec = writes_reg(set_en, set_addr) ? (NUM_REGS'(1) << set_addr) : '0;
  assign w_clr_vec = writes_reg(clr_en, clr_addr) ? (NUM_REGS'(1) << clr_addr) : '0;

  // Clear first, then OR in the set so a same-address set takes priority.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_busy <= '0;
    end else begin
      r_busy <= (r_busy & ~w_clr_vec) | w_set_vec;
    end
  end

  assign look_a_busy = r_busy[look_a_addr];
  assign look_b_busy = r_busy[look_b_addr];

endmodule
`default_nettype wire

// File: rtl/id_regfile_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module  : id_regfile_scoreboard
//  Purpose : 32x32 MIPS register file at the consumer end of the writeback
//            path, with two zero-latency read ports for ID and a busy
//            scoreboard that stalls ID while a source has a pending producer.
//  Ports   : clk  in  clock, rising edge
//            rst  in  asynchronous active-low reset
//            bus  id_regfile_scoreboard_if.slave
//                 (wb_en/wb_addr/wb_data, rs_addr/rt_addr, rs_data/rt_data,
//                  issue_en/issue_addr, stall)
//  Config  : REGFILE_BYPASS_EN - when defined, a read of the register being
//            written this cycle returns wb_data and the matching busy bit is
//            treated as already retired, so stall drops in the writeback
//            cycle. When undefined, reads return the stored value and stall
//            drops the cycle after writeback.
//  Revision: 1.0 - initial release
// ============================================================================
module id_regfile_scoreboard
  import mips_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  id_regfile_scoreboard_if.slave  bus
);

  word_t r_regs [NUM_REGS];

  logic  w_wb_write;
  logic  w_rs_hit;
  logic  w_rt_hit;
  logic  w_rs_busy;
  logic  w_rt_busy;
  word_t w_rs_read;
  word_t w_rt_read;

  assign w_wb_write = writes_reg(bus.wb_en, bus.wb_addr);

  // Entry 0 is reset and never written, but reads of address 0 are forced
  // to zero anyway so the hardwired behaviour does not depend on storage.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_wb_write) begin
      r_regs[bus.wb_addr] <= bus.wb_data;
    end
  end

  // Same-cycle writeback hits: they forward data and mask the busy bit.
`ifdef REGFILE_BYPASS_EN
  assign w_rs_hit = w_wb_write && (bus.wb_addr == bus.rs_addr);
  assign w_rt_hit = w_wb_write && (bus.wb_addr == bus.rt_addr);
`else
  assign w_rs_hit = 1'b0;
  assign w_rt_hit = 1'b0;
`endif

  always_comb begin
    w_rs_read = r_regs[bus.rs_addr];
    if (bus.rs_addr == REG_ZERO) begin
      w_rs_read = '0;
    end else if (w_rs_hit) begin
      w_rs_read = bus.wb_data;
    end
  end

  always_comb begin
    w_rt_read = r_regs[bus.rt_addr];
    if (bus.rt_addr == REG_ZERO) begin
      w_rt_read = '0;
    end else if (w_rt_hit) begin
      w_rt_read = bus.wb_data;
    end
  end

  // While reset is held the forwarding path must not leak wb_data.
  assign bus.rs_data = rst ? w_rs_read : '0;
  assign bus.rt_data = rst ? w_rt_read : '0;

  busy_scoreboard u_busy (
    .clk         (clk),
    .rst         (rst),
    .set_en      (bus.issue_en),
    .set_addr    (bus.issue_addr),
    .clr_en      (bus.wb_en),
    .clr_addr    (bus.wb_addr),
    .look_a_addr (bus.rs_addr),
    .look_b_addr (bus.rt_addr),
    .look_a_busy (w_rs_busy),
    .look_b_busy (w_rt_busy)
  );

  assign bus.stall = (w_rs_busy && !w_rs_hit) || (w_rt_busy && !w_rt_hit);

endmodule
`default_nettype wire

// File: tb/tb_id_regfile_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module  : tb_id_regfile_scoreboard
//  Purpose : Self-checking bench for id_regfile_scoreboard. A driver applies
//            directed and random stimulus and pushes the reference model's
//            expected rs_data/rt_data/stall into a queue; a monitor pops and
//            compares against the DUT each cycle.
//  Config  : REGFILE_BYPASS_EN (must match the RTL build)
//  Revision: 1.0 - initial release
// ============================================================================
module tb_id_regfile_scoreboard;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  typedef struct {
    logic [31:0] rs;
    logic [31:0] rt;
    logic        stall;
    int          cyc;
  } exp_t;

  logic clk;
  logic rst;

  id_regfile_scoreboard_if bus ();

  id_regfile_scoreboard dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  logic [31:0] m_regs [32];
  bit          m_busy [32];

  exp_t q[$];
  int   n_pass  = 0;
  int   n_total = 0;
  int   cyc     = 0;

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      m_regs[i] = 32'h0;
      m_busy[i] = 1'b0;
    end
  endtask

  // One cycle: drive after the falling edge, predict outputs, then apply
  // the clock-edge effects to the model.
  task automatic step(input logic r, input logic we, input logic [4:0] wa,
                      input logic [31:0] wd, input logic [4:0] ra,
                      input logic [4:0] rb, input logic ie, input logic [4:0] ia);
    exp_t e;
    bit   wr;
    @(negedge clk);
    #1;
    rst            = r;
    bus.wb_en      = we;
    bus.wb_addr    = wa;
    bus.wb_data    = wd;
    bus.rs_addr    = ra;
    bus.rt_addr    = rb;
    bus.issue_en   = ie;
    bus.issue_addr = ia;
    if (!r) model_reset();
    wr = we && (wa != 5'd0);
    e.cyc = cyc;
    if (!r) begin
      e.rs = 32'h0; e.rt = 32'h0; e.stall = 1'b0;
    end else begin
      e.rs = (ra == 5'd0) ? 32'h0 : (BYPASS && wr && wa == ra) ? wd : m_regs[ra];
      e.rt = (rb == 5'd0) ? 32'h0 : (BYPASS && wr && wa == rb) ? wd : m_regs[rb];
      e.stall = (m_busy[ra] && !(BYPASS && wr && wa == ra)) ||
                (m_busy[rb] && !(BYPASS && wr && wa == rb));
    end
    q.push_back(e);
    @(posedge clk);
    cyc++;
    if (r) begin
      if (wr) begin
        m_regs[wa] = wd;
        m_busy[wa] = 1'b0;
      end
      if (ie && ia != 5'd0) m_busy[ia] = 1'b1;
    end
  endtask

  task automatic check32(input string name, input int c,
                         input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s cycle %0d: got %h expected %h", name, c, got, exp);
  endtask

  // Monitor: outputs are combinational, so every cycle presents a response.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #3;
      while (q.size() > 0) begin
        e = q.pop_front();
        check32("rs_data", e.cyc, bus.rs_data, e.rs);
        check32("rt_data", e.cyc, bus.rt_data, e.rt);
        check32("stall",   e.cyc, {31'h0, bus.stall}, {31'h0, e.stall});
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [4:0] a, b, c, d;
    rst = 1'b0;
    bus.wb_en = 1'b0; bus.wb_addr = '0; bus.wb_data = '0;
    bus.rs_addr = '0; bus.rt_addr = '0;
    bus.issue_en = 1'b0; bus.issue_addr = '0;
    model_reset();

    // Reset held with random inputs
    for (int i = 0; i < 4; i++)
      step(1'b0, 1'b1, 5'($urandom), $urandom, 5'($urandom), 5'($urandom),
           1'b1, 5'($urandom));

    // Every register reads zero after release
    for (int i = 1; i < 32; i += 2)
      step(1'b1, 1'b0, 5'd0, 32'h0, 5'(i), 5'(i + 1), 1'b0, 5'd0);

    // Write r8 then read it
    step(1'b1, 1'b1, 5'd8, 32'hDEADBEEF, 5'd8, 5'd0, 1'b0, 5'd0);
    step(1'b1, 1'b0, 5'd0, 32'h0, 5'd8, 5'd8, 1'b0, 5'd0);

    // Write to r0 is discarded
    step(1'b1, 1'b1, 5'd0, 32'h1234, 5'd0, 5'd0, 1'b0, 5'd0);
    step(1'b1, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b0, 5'd0);
    step(1'b1, 1'b0, 5'd0, 32'h0, 5'd0, 5'd8, 1'b0, 5'd0);

    // Same-cycle read of r5 while it is written
    step(1'b1, 1'b1, 5'd5, 32'hA5A5A5A5, 5'd5, 5'd5, 1'b0, 5'd0);
    step(1'b1, 1'b0, 5'd0, 32'h0, 5'd5, 5'd0, 1'b0, 5'd0);

    // Producer to r9 stalls a reader until writeback
    step(1'b1, 1'b0, 5'd0, 32'h0, 5'd0, 5'd9, 1'b1, 5'd9);
    for (int i = 0; i < 3; i++)
      step(1'b1, 1'b0, 5'd0, 32'h0, 5'd1, 5'd9, 1'b0, 5'd0);
    step(1'b1, 1'b1, 5'd9, 32'h77, 5'd0, 5'd9, 1'b0, 5'd0);
    step(1'b1, 1'b0, 5'd0, 32'h0, 5'd0, 5'd9, 1'b0, 5'd0);

    // Repeated issue keeps r4 busy; a single writeback clears it
    step(1'b1, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b1, 5'd4);
    step(1'b1, 1'b0, 5'd0, 32'h0, 5'd4, 5'd0, 1'b1, 5'd4);
    step(1'b1, 1'b1, 5'd4, 32'h44, 5'd4, 5'd0, 1'b0, 5'd0);
    step(1'b1, 1'b0, 5'd0, 32'h0, 5'd4, 5'd4, 1'b0, 5'd0);

    // Set and clear of r3 together: set wins; then reset mid-stall
    step(1'b1, 1'b1, 5'd3, 32'h33, 5'd0, 5'd0, 1'b1, 5'd3);
    step(1'b1, 1'b0, 5'd0, 32'h0, 5'd3, 5'd0, 1'b0, 5'd0);
    step(1'b0, 1'b1, 5'd3, 32'h99, 5'd3, 5'd8, 1'b0, 5'd0);
    step(1'b1, 1'b0, 5'd0, 32'h0, 5'd3, 5'd8, 1'b0, 5'd0);

    // Random traffic, addresses biased to a small set to provoke hazards
    for (int i = 0; i < 500; i++) begin
      a = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 7)) : 5'($urandom);
      b = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 7)) : 5'($urandom);
      c = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 7)) : 5'($urandom);
      d = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 7)) : 5'($urandom);
      step(($urandom_range(0, 49) != 0), ($urandom_range(0, 1) == 1), a, $urandom,
           b, c, ($urandom_range(0, 3) == 0), d);
    end

    repeat (2) @(negedge clk);
    #5;
    if (q.size() != 0) begin
      n_total++;
      $display("FAIL drain: %0d expected responses left unchecked, required 0", q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
